// File: rtl/ram_arb_pkg.sv
// Shared encodings for the RAM port arbiter: FSM states, owner codes and the
// default hold limit used when RAM_ARB_HOLD_TIMEOUT_EN is defined.
package ram_arb_pkg;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] OWN_IF = 2'd1;
  localparam logic [1:0] OWN_DM = 2'd2;

  localparam logic OWN_SEL_IF = 1'b0;
  localparam logic OWN_SEL_DM = 1'b1;

  localparam int unsigned MAX_HOLD_DEFAULT = 16;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-requester round-robin picker: on contention the requester
// opposite last_owner wins, otherwise the lone requester is picked.
module rr_pick2
  import ram_arb_pkg::*;
(
  input  logic req_if,
  input  logic req_dm,
  input  logic last_owner,
  output logic pick_valid,
  output logic pick_owner
);

  always_comb begin
    pick_valid = req_if | req_dm;
    if (req_if && req_dm) begin
      pick_owner = ~last_owner;
    end else if (req_dm) begin
      pick_owner = OWN_SEL_DM;
    end else begin
      pick_owner = OWN_SEL_IF;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Burst-granular arbiter sharing one byte-wide RAM port between the fetch and
// data shims. Optional forced release after MAX_HOLD cycles: RAM_ARB_HOLD_TIMEOUT_EN.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 8,
  parameter int MAX_HOLD = MAX_HOLD_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              last_owner,
`ifdef RAM_ARB_HOLD_TIMEOUT_EN
  output logic              hold_err,
`endif
  output logic [1:0]        state_dbg
);

  // Handshake: a master raises req and keeps it high for its whole burst; the
  // port is its own from the edge gnt rises until the edge req is sampled low.

  logic [1:0] state;
  logic [1:0] state_nx;
  logic       owned;
  logic       owner_done;
  logic       hold_hit;
  logic       pick_valid;
  logic       pick_owner;
  logic       grant_new;

  assign owned = (state == OWN_IF) || (state == OWN_DM);

  // The releasing owner is masked out so the picker only sees the other master.
  rr_pick2 u_pick (
    .req_if     (if_req && (state != OWN_IF)),
    .req_dm     (dm_req && (state != OWN_DM)),
    .last_owner (last_owner),
    .pick_valid (pick_valid),
    .pick_owner (pick_owner)
  );

  always_comb begin
    owner_done = 1'b0;
    case (state)
      OWN_IF:  owner_done = !if_req || hold_hit;
      OWN_DM:  owner_done = !dm_req || hold_hit;
      default: owner_done = 1'b0;
    endcase
  end

  assign grant_new = pick_valid && (!owned || owner_done);

  always_comb begin
    state_nx = state;
    if (!owned || owner_done) begin
      if (pick_valid) begin
        state_nx = (pick_owner == OWN_SEL_DM) ? OWN_DM : OWN_IF;
      end else begin
        state_nx = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      if_gnt     <= 1'b0;
      dm_gnt     <= 1'b0;
      last_owner <= OWN_SEL_DM;
    end else begin
      state  <= state_nx;
      if_gnt <= (state_nx == OWN_IF);
      dm_gnt <= (state_nx == OWN_DM);
      if (grant_new) begin
        last_owner <= pick_owner;
      end
    end
  end

`ifdef RAM_ARB_HOLD_TIMEOUT_EN
  localparam int CNT_W = $clog2(MAX_HOLD) + 1;

  logic [CNT_W-1:0] hold_cnt;

  // hold_cnt is 0 in the first owned cycle, so the limit hits on the MAX_HOLD-th edge.
  assign hold_hit = owned && (hold_cnt == CNT_W'(MAX_HOLD - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_cnt <= '0;
      hold_err <= 1'b0;
    end else begin
      if (grant_new) begin
        hold_cnt <= '0;
      end else if (owned) begin
        hold_cnt <= hold_cnt + CNT_W'(1);
      end
      if (hold_hit) begin
        hold_err <= 1'b1;
      end
    end
  end
`else
  assign hold_hit = 1'b0;
`endif

  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    case (state)
      OWN_IF: begin
        ram_en   = 1'b1;
        ram_addr = if_addr;
      end
      OWN_DM: begin
        ram_en    = 1'b1;
        ram_we    = dm_we;
        ram_addr  = dm_addr;
        ram_wdata = dm_wdata;
      end
      default: begin
        ram_en = 1'b0;
      end
    endcase
  end

  assign rdata     = ram_rdata;
  assign busy      = if_gnt | dm_gnt;
  assign state_dbg = state;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: vector table, directed corner
// sequences and a randomized run against an owner-level reference model.
module tb_ram_port_arbiter;
  import ram_arb_pkg::*;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 8;
`ifdef RAM_ARB_HOLD_TIMEOUT_EN
  localparam int HOLD = 4;
`else
  localparam int HOLD = 16;
`endif

  logic              clk;
  logic              reset;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_gnt;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic [DATA_W-1:0] rdata;
  logic              busy;
  logic              last_owner;
  logic [1:0]        state_dbg;
`ifdef RAM_ARB_HOLD_TIMEOUT_EN
  logic              hold_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [0:0] exp_q[$];

  ram_port_arbiter #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .MAX_HOLD (HOLD)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_gnt     (if_gnt),
    .dm_req     (dm_req),
    .dm_we      (dm_we),
    .dm_addr    (dm_addr),
    .dm_wdata   (dm_wdata),
    .dm_gnt     (dm_gnt),
    .ram_en     (ram_en),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata),
    .rdata      (rdata),
    .busy       (busy),
    .last_owner (last_owner),
`ifdef RAM_ARB_HOLD_TIMEOUT_EN
    .hold_err   (hold_err),
`endif
    .state_dbg  (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_inputs(input logic ir, input logic dr, input logic we,
                            input logic [31:0] ia, input logic [31:0] da,
                            input logic [7:0] wd);
    if_req   = ir;
    dm_req   = dr;
    dm_we    = we;
    if_addr  = ia;
    dm_addr  = da;
    dm_wdata = wd;
    ram_rdata = DATA_W'($urandom_range(0, 255));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    set_inputs(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic eif, input logic edm,
                           input logic ewe, input logic [31:0] eaddr,
                           input logic [7:0] ewd, input logic elast);
    logic [1:0] est;
    est = eif ? OWN_IF : (edm ? OWN_DM : IDLE);
    check({tag, ".if_gnt"},     32'(if_gnt),     32'(eif));
    check({tag, ".dm_gnt"},     32'(dm_gnt),     32'(edm));
    check({tag, ".busy"},       32'(busy),       32'(eif | edm));
    check({tag, ".ram_en"},     32'(ram_en),     32'(eif | edm));
    check({tag, ".ram_we"},     32'(ram_we),     32'(ewe));
    check({tag, ".ram_addr"},   ram_addr,        eaddr);
    check({tag, ".ram_wdata"},  32'(ram_wdata),  32'(ewd));
    check({tag, ".last_owner"}, 32'(last_owner), 32'(elast));
    check({tag, ".state"},      32'(state_dbg),  32'(est));
    check({tag, ".rdata"},      32'(rdata),      32'(ram_rdata));
  endtask

  // ---------------- driver: one clock step ----------------
  task automatic step(input logic ir, input logic dr, input logic we,
                      input logic [31:0] ia, input logic [31:0] da, input logic [7:0] wd);
    @(negedge clk);
    set_inputs(ir, dr, we, ia, da, wd);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        if_req, dm_req, dm_we;
    logic [31:0] if_addr, dm_addr;
    logic [7:0]  dm_wdata;
    logic        e_if, e_dm, e_we;
    logic [31:0] e_addr;
    logic [7:0]  e_wd;
    logic        e_last;
  } vec_t;

  function automatic vec_t mk(logic ir, logic dr, logic we, logic [31:0] ia,
                              logic [31:0] da, logic [7:0] wd, logic eif, logic edm,
                              logic ewe, logic [31:0] ea, logic [7:0] ewd, logic el);
    vec_t v;
    v.if_req = ir; v.dm_req = dr; v.dm_we = we;
    v.if_addr = ia; v.dm_addr = da; v.dm_wdata = wd;
    v.e_if = eif; v.e_dm = edm; v.e_we = ewe;
    v.e_addr = ea; v.e_wd = ewd; v.e_last = el;
    return v;
  endfunction

  initial begin
    vec_t vecs[16];
    int   m_owner, m_last, m_held;
    bit   m_err;
    int   cnt_if, cnt_dm;
    logic prev_if, prev_dm, seen_grant;
    logic ir, dr;

    reset = 1'b0;
    set_inputs(0, 0, 0, 0, 0, 0);

    // Vector table: single fetch, data write, contention, handover, fairness.
    vecs[0]  = mk(1, 0, 0, 'h100, 0, 0,            1, 0, 0, 'h100, 0, 0);
    vecs[1]  = mk(1, 0, 0, 'h101, 0, 0,            1, 0, 0, 'h101, 0, 0);
    vecs[2]  = mk(1, 0, 0, 'h102, 0, 0,            1, 0, 0, 'h102, 0, 0);
    vecs[3]  = mk(1, 0, 1, 'h103, 'h9, 'hFF,       1, 0, 0, 'h103, 0, 0);
    vecs[4]  = mk(0, 0, 0, 'h104, 0, 0,            0, 0, 0, 0, 0, 0);
    vecs[5]  = mk(0, 1, 1, 0, 'h2000, 'hA5,        0, 1, 1, 'h2000, 'hA5, 1);
    vecs[6]  = mk(0, 1, 1, 0, 'h2001, 'h5A,        0, 1, 1, 'h2001, 'h5A, 1);
    vecs[7]  = mk(0, 0, 1, 0, 'h2002, 'h77,        0, 0, 0, 0, 0, 1);
    vecs[8]  = mk(1, 1, 1, 'h300, 'h400, 'h11,     1, 0, 0, 'h300, 0, 0);
    vecs[9]  = mk(1, 1, 1, 'h300, 'h400, 'h11,     1, 0, 0, 'h300, 0, 0);
    vecs[10] = mk(0, 1, 1, 'h300, 'h400, 'h11,     0, 1, 1, 'h400, 'h11, 1);
    vecs[11] = mk(1, 1, 0, 'h300, 'h400, 'h11,     0, 1, 0, 'h400, 'h11, 1);
    vecs[12] = mk(1, 0, 0, 'h300, 'h400, 'h11,     1, 0, 0, 'h300, 0, 0);
    vecs[13] = mk(0, 0, 0, 'h300, 'h400, 'h11,     0, 0, 0, 0, 0, 0);
    vecs[14] = mk(1, 1, 0, 'h500, 'h600, 'h22,     0, 1, 0, 'h600, 'h22, 1);
    vecs[15] = mk(0, 0, 0, 'h500, 'h600, 'h22,     0, 0, 0, 0, 0, 1);

    do_reset();
    #1;
    check_all("reset", 0, 0, 0, 0, 0, 1);

    for (int i = 0; i < 16; i++) begin
      step(vecs[i].if_req, vecs[i].dm_req, vecs[i].dm_we,
           vecs[i].if_addr, vecs[i].dm_addr, vecs[i].dm_wdata);
      check_all($sformatf("vec%0d", i), vecs[i].e_if, vecs[i].e_dm, vecs[i].e_we,
                vecs[i].e_addr, vecs[i].e_wd, vecs[i].e_last);
    end

    // Fairness: both masters always want the port, 3-cycle bursts.
    do_reset();
    exp_q.delete();
    exp_q.push_back(OWN_SEL_IF);
    cnt_if = 0; cnt_dm = 0;
    prev_if = 1'b0; prev_dm = 1'b0; seen_grant = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      cnt_if = if_gnt ? cnt_if + 1 : 0;
      cnt_dm = dm_gnt ? cnt_dm + 1 : 0;
      ir = !(if_gnt && cnt_if == 3);
      dr = !(dm_gnt && cnt_dm == 3);
      set_inputs(ir, dr, 1'b0, 'h40 + 32'(c), 'h80 + 32'(c), 8'(c));
      @(posedge clk);
      #1;
      check("fair.no_overlap", 32'(if_gnt & dm_gnt), 0);
      if (seen_grant) check("fair.no_idle_gap", 32'(busy), 1);
      if ((if_gnt && !prev_if) || (dm_gnt && !prev_dm)) begin
        seen_grant = 1'b1;
        if (exp_q.size() == 0) begin
          check("fair.queue_empty", 1, 0);
        end else begin
          check("fair.grant_order", 32'(dm_gnt), 32'(exp_q[0]));
          exp_q.push_back(~exp_q[0]);
          void'(exp_q.pop_front());
        end
      end
      prev_if = if_gnt;
      prev_dm = dm_gnt;
    end
    check("fair.grant_count", 32'(exp_q.size() == 1 && seen_grant), 1);
    step(0, 0, 0, 0, 0, 0);

    // Mid-burst reset during a data write, fetch already waiting.
    do_reset();
    step(0, 1, 1, 0, 'h3000, 'hC3);
    check_all("mrst.own", 0, 1, 1, 'h3000, 'hC3, 1);
    #2;
    reset  = 1'b0;
    if_req = 1'b1;
    if_addr = 'h700;
    #1;
    check("mrst.if_gnt", 32'(if_gnt), 0);
    check("mrst.dm_gnt", 32'(dm_gnt), 0);
    check("mrst.ram_en", 32'(ram_en), 0);
    check("mrst.ram_we", 32'(ram_we), 0);
    check("mrst.last_owner", 32'(last_owner), 1);
    @(negedge clk);
    reset  = 1'b1;
    dm_req = 1'b0;
    @(posedge clk);
    #1;
    check_all("mrst.regrant", 1, 0, 0, 'h700, 0, 0);
    step(0, 0, 0, 0, 0, 0);

`ifdef RAM_ARB_HOLD_TIMEOUT_EN
    // Hold timeout: data master never lets go, fetch is waiting.
    do_reset();
    step(0, 1, 1, 'h10, 'h20, 'h33);
    check("tmo.dm_gnt0", 32'(dm_gnt), 1);
    for (int k = 0; k < HOLD - 1; k++) begin
      step(1, 1, 1, 'h10, 'h20, 'h33);
      check("tmo.dm_held", 32'(dm_gnt), 1);
      check("tmo.err_low", 32'(hold_err), 0);
    end
    step(1, 1, 1, 'h10, 'h20, 'h33);
    check_all("tmo.handover", 1, 0, 0, 'h10, 0, 0);
    check("tmo.hold_err", 32'(hold_err), 1);
    step(0, 1, 1, 'h10, 'h20, 'h33);
    check("tmo.back_to_dm", 32'(dm_gnt), 1);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    check("tmo.err_sticky", 32'(hold_err), 1);
`endif

    // Randomized run against an owner-level model (-1 none, 0 fetch, 1 data).
    do_reset();
    m_owner = -1; m_last = 1; m_held = 0; m_err = 1'b0;
    ir = 1'b0; dr = 1'b0;
    for (int c = 0; c < 400; c++) begin
      int   nxt;
      bit   tmo, newg;
      logic r[2];
      ir = ir ? ($urandom_range(0, 99) < 80) : ($urandom_range(0, 99) < 40);
      dr = dr ? ($urandom_range(0, 99) < 80) : ($urandom_range(0, 99) < 40);
      step(ir, dr, 1'($urandom_range(0, 1)), $urandom, $urandom, 8'($urandom_range(0, 255)));
      r[0] = ir; r[1] = dr;
      tmo = 1'b0;
`ifdef RAM_ARB_HOLD_TIMEOUT_EN
      tmo = (m_owner >= 0) && (m_held + 1 == HOLD);
`endif
      if (m_owner < 0) begin
        if (r[0] && r[1]) nxt = 1 - m_last;
        else if (r[0])    nxt = 0;
        else if (r[1])    nxt = 1;
        else              nxt = -1;
        newg = (nxt >= 0);
      end else if (!r[m_owner] || tmo) begin
        nxt  = r[1 - m_owner] ? 1 - m_owner : -1;
        newg = (nxt >= 0);
      end else begin
        nxt  = m_owner;
        newg = 1'b0;
      end
      if (tmo) m_err = 1'b1;
      if (newg) begin
        m_last = nxt;
        m_held = 0;
      end else if (m_owner >= 0) begin
        m_held++;
      end
      m_owner = nxt;
      check_all($sformatf("rand%0d", c), m_owner == 0, m_owner == 1,
                (m_owner == 1) && dm_we,
                (m_owner == 0) ? if_addr : ((m_owner == 1) ? dm_addr : 32'h0),
                (m_owner == 1) ? dm_wdata : 8'h0, 1'(m_last));
`ifdef RAM_ARB_HOLD_TIMEOUT_EN
      check($sformatf("rand%0d.hold_err", c), 32'(hold_err), 32'(m_err));
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog so a stuck run still reports.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
